// File: rtl/score_keeper.sv
// Scorekeeper for the pong game: detects ball-out edges, keeps both scores,
// emits goal/win pulses and freezes play while the LED animation runs.
// Ports:
//   BALL_CLOCK, RESET_N      : clock and synchronous active-low reset
//   ball_out_left/right      : level inputs from the ball logic
//   start                    : new-game request (level)
//   goal_player_x, win_player_x : one-cycle event pulses for the animator
//   score_1, score_2         : current scores
//   game_freeze              : hold the ball at centre while high
//   serve_dir                : 0 = serve toward player 1, 1 = toward player 2
module score_keeper #(
  parameter int WIN_SCORE  = 5,
  parameter int SCORE_W    = 4,
  parameter int HOLD_TICKS = 28
) (
  input  logic               BALL_CLOCK,
  input  logic               RESET_N,
  input  logic               ball_out_left,
  input  logic               ball_out_right,
  input  logic               start,
  output logic               goal_player_1,
  output logic               goal_player_2,
  output logic               win_player_1,
  output logic               win_player_2,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic               game_freeze,
  output logic               serve_dir
);

  localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    PLAY,
    GOAL_HOLD,
    WIN_HOLD,
    GAME_OVER
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [SCORE_W-1:0] s1_q;
  logic [SCORE_W-1:0] s2_q;
  logic               g1_q;
  logic               g2_q;
  logic               w1_q;
  logic               w2_q;
  logic               frz_q;
  logic               srv_q;
  logic               left_q;
  logic               right_q;
  logic               start_q;

  logic               rise_l;
  logic               rise_r;
  logic               rise_s;
  logic [SCORE_W-1:0] s1_inc;
  logic [SCORE_W-1:0] s2_inc;

  assign rise_l = ball_out_left & ~left_q;
  assign rise_r = ball_out_right & ~right_q;
  assign rise_s = start & ~start_q;
  assign s1_inc = s1_q + SCORE_W'(1);
  assign s2_inc = s2_q + SCORE_W'(1);

  always_ff @(posedge BALL_CLOCK) begin
    // History always tracks the inputs, including through reset and holds,
    // so a level held across either never looks like a fresh edge.
    left_q  <= ball_out_left;
    right_q <= ball_out_right;
    start_q <= start;
    if (!RESET_N) begin
      state_q <= PLAY;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      w1_q    <= 1'b0;
      w2_q    <= 1'b0;
      frz_q   <= 1'b0;
      srv_q   <= 1'b0;
    end else begin
      g1_q <= 1'b0;
      g2_q <= 1'b0;
      w1_q <= 1'b0;
      w2_q <= 1'b0;
      unique case (state_q)
        PLAY: begin
          // Simultaneous edges on both sides are ambiguous: no event.
          if (rise_l ^ rise_r) begin
            frz_q <= 1'b1;
            cnt_q <= HOLD_LD;
            if (rise_r) begin
              s1_q  <= s1_inc;
              srv_q <= 1'b1;
              if (s1_inc == WIN) begin
                w1_q    <= 1'b1;
                state_q <= WIN_HOLD;
              end else begin
                g1_q    <= 1'b1;
                state_q <= GOAL_HOLD;
              end
            end else begin
              s2_q  <= s2_inc;
              srv_q <= 1'b0;
              if (s2_inc == WIN) begin
                w2_q    <= 1'b1;
                state_q <= WIN_HOLD;
              end else begin
                g2_q    <= 1'b1;
                state_q <= GOAL_HOLD;
              end
            end
          end
        end
        GOAL_HOLD, WIN_HOLD: begin
          if (cnt_q == '0) begin
            if (state_q == GOAL_HOLD) begin
              state_q <= PLAY;
              frz_q   <= 1'b0;
            end else begin
              state_q <= GAME_OVER;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        GAME_OVER: begin
          if (rise_s) begin
            s1_q    <= '0;
            s2_q    <= '0;
            srv_q   <= 1'b0;
            frz_q   <= 1'b0;
            state_q <= PLAY;
          end
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  assign goal_player_1 = g1_q;
  assign goal_player_2 = g2_q;
  assign win_player_1  = w1_q;
  assign win_player_2  = w2_q;
  assign score_1       = s1_q;
  assign score_2       = s2_q;
  assign game_freeze   = frz_q;
  assign serve_dir     = srv_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios then random play, every
// cycle compared against an event-level model of the game rules.
module tb_score_keeper;

  localparam int WS = 3;
  localparam int SW = 4;
  localparam int HT = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bl;
  logic          br;
  logic          st;
  logic          g1;
  logic          g2;
  logic          w1;
  logic          w2;
  logic [SW-1:0] sc1;
  logic [SW-1:0] sc2;
  logic          frz;
  logic          srv;

  score_keeper #(
    .WIN_SCORE (WS),
    .SCORE_W   (SW),
    .HOLD_TICKS(HT)
  ) dut (
    .BALL_CLOCK    (clk),
    .RESET_N       (rst_n),
    .ball_out_left (bl),
    .ball_out_right(br),
    .start         (st),
    .goal_player_1 (g1),
    .goal_player_2 (g2),
    .win_player_1  (w1),
    .win_player_2  (w2),
    .score_1       (sc1),
    .score_2       (sc2),
    .game_freeze   (frz),
    .serve_dir     (srv)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: rule-level game state, time measured in edges.
  int k = 0;
  int hold_end = -1;
  int m_s1;
  int m_s2;
  bit m_over;
  bit m_won;
  bit m_srv;
  bit m_frz;
  bit m_g1;
  bit m_g2;
  bit m_w1;
  bit m_w2;
  bit pl;
  bit pr;
  bit ps;
  bit live = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_step();
    bit rl;
    bit rr;
    bit rs;
    k++;
    rl = bl && !pl;
    rr = br && !pr;
    rs = st && !ps;
    m_g1 = 0;
    m_g2 = 0;
    m_w1 = 0;
    m_w2 = 0;
    if (!rst_n) begin
      live = 1;
      m_s1 = 0;
      m_s2 = 0;
      m_over = 0;
      m_won = 0;
      m_srv = 0;
      hold_end = -1;
    end else if (m_over) begin
      if (rs) begin
        m_s1 = 0;
        m_s2 = 0;
        m_srv = 0;
        m_over = 0;
      end
    end else if (k == hold_end) begin
      if (m_won) m_over = 1;
    end else if (k > hold_end && (rl != rr)) begin
      if (rr) begin
        m_s1++;
        m_srv = 1;
        m_won = (m_s1 == WS);
        if (m_won) m_w1 = 1;
        else m_g1 = 1;
      end else begin
        m_s2++;
        m_srv = 0;
        m_won = (m_s2 == WS);
        if (m_won) m_w2 = 1;
        else m_g2 = 1;
      end
      hold_end = k + HT;
    end
    pl = bl;
    pr = br;
    ps = st;
    m_frz = m_over || (k < hold_end);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (live) begin
      chk("goal1", 32'(g1), 32'(m_g1));
      chk("goal2", 32'(g2), 32'(m_g2));
      chk("win1", 32'(w1), 32'(m_w1));
      chk("win2", 32'(w2), 32'(m_w2));
      chk("score1", 32'(sc1), 32'(m_s1));
      chk("score2", 32'(sc2), 32'(m_s2));
      chk("freeze", 32'(frz), 32'(m_frz));
      chk("serve", 32'(srv), 32'(m_srv));
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic right_goal();
    br = 1'b1;
    tick();
    br = 1'b0;
    ticks(HT + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bl = 1'b0;
    br = 1'b0;
    st = 1'b0;
    tick();
    tick();
    chk("rst_score1", 32'(sc1), 32'd0);
    chk("rst_freeze", 32'(frz), 32'd0);
    rst_n = 1'b1;
    ticks(3);

    // Single right edge: pulse next cycle, freeze for exactly HT cycles.
    br = 1'b1;
    tick();
    chk("t1_goal1", 32'(g1), 32'd1);
    chk("t1_score1", 32'(sc1), 32'd1);
    chk("t1_serve", 32'(srv), 32'd1);
    br = 1'b0;
    tick();
    chk("t1_pulse_len", 32'(g1), 32'd0);
    ticks(3);
    chk("t1_frz_last", 32'(frz), 32'd1);
    tick();
    chk("t1_frz_drop", 32'(frz), 32'd0);

    // Held left level fires once.
    bl = 1'b1;
    ticks(20);
    chk("t2_score2", 32'(sc2), 32'd1);
    bl = 1'b0;
    tick();

    // Simultaneous edges: no event.
    do_reset();
    bl = 1'b1;
    br = 1'b1;
    tick();
    chk("t3_goal1", 32'(g1), 32'd0);
    chk("t3_goal2", 32'(g2), 32'd0);
    chk("t3_freeze", 32'(frz), 32'd0);
    bl = 1'b0;
    br = 1'b0;
    ticks(2);
    chk("t3_score1", 32'(sc1), 32'd0);

    // Three right edges: goal, goal, win; then game over until start.
    do_reset();
    right_goal();
    right_goal();
    br = 1'b1;
    tick();
    chk("t4_win1", 32'(w1), 32'd1);
    chk("t4_nogoal", 32'(g1), 32'd0);
    chk("t4_score1", 32'(sc1), 32'd3);
    br = 1'b0;
    ticks(10);
    right_goal();
    chk("t4_over_frz", 32'(frz), 32'd1);
    chk("t4_over_sc", 32'(sc1), 32'd3);
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    chk("t4_new_sc", 32'(sc1), 32'd0);
    chk("t4_new_frz", 32'(frz), 32'd0);
    chk("t4_new_srv", 32'(srv), 32'd0);

    // Edge during a goal hold is dropped.
    br = 1'b1;
    tick();
    br = 1'b0;
    tick();
    br = 1'b1;
    tick();
    br = 1'b0;
    ticks(HT + 1);
    chk("t5_ignored", 32'(sc1), 32'd1);
    br = 1'b1;
    tick();
    chk("t5_counted", 32'(sc1), 32'd2);
    chk("t5_goal1", 32'(g1), 32'd1);
    br = 1'b0;
    ticks(HT + 1);

    // Reset in the middle of a win hold.
    do_reset();
    right_goal();
    right_goal();
    br = 1'b1;
    tick();
    br = 1'b0;
    ticks(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_score1", 32'(sc1), 32'd0);
    chk("t6_freeze", 32'(frz), 32'd0);
    chk("t6_win1", 32'(w1), 32'd0);
    ticks(3);

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) bl = ~bl;
      if ($urandom_range(7) == 0) br = ~br;
      if ($urandom_range(9) == 0) st = ~st;
      rst_n = ($urandom_range(299) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
